// File: rtl/mult_sequencer_if.sv
// ----------------------------------------------------------------------------
// mult_sequencer_if
//   Operator-facing signal bundle for the shift-add multiplier sequencer.
//
//   Controls (driven by the master, i.e. the switch/button front end):
//     Run           start request; a new multiply begins on its rising edge
//     ClearA_LoadB  clear A and X, load B from Sw
//     Sw            operand switches (multiplier on load, multiplicand on run)
//   Status (driven by the slave, i.e. mult_sequencer):
//     Aval          accumulator A, product high byte
//     Bval          multiplier / product low byte
//     Xval          sign-extension bit of the 9-bit X:A accumulator
//     Done          sequencer parked in HOLD with a finished product
//     Busy          sequencer stepping through ADD/SHIFT
// ----------------------------------------------------------------------------
interface mult_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             Run;
    logic             ClearA_LoadB;
    logic [WIDTH-1:0] Sw;
    logic [WIDTH-1:0] Aval;
    logic [WIDTH-1:0] Bval;
    logic             Xval;
    logic             Done;
    logic             Busy;

    modport master (
        output Run,
        output ClearA_LoadB,
        output Sw,
        input  Aval,
        input  Bval,
        input  Xval,
        input  Done,
        input  Busy
    );

    modport slave (
        input  Run,
        input  ClearA_LoadB,
        input  Sw,
        output Aval,
        output Bval,
        output Xval,
        output Done,
        output Busy
    );
endinterface

// File: rtl/mult_sequencer.sv
// ----------------------------------------------------------------------------
// mult_sequencer
//   Sequencer and operand registers for a WIDTH x WIDTH signed shift-add
//   multiplier. Each Run rising edge latches the multiplicand M from Sw and
//   performs WIDTH add-then-shift steps on {X,A,B}; the final step subtracts
//   M because the multiplier's top bit carries negative weight in two's
//   complement. The signed product is left in A:B with X as its sign.
//
//   Ports:
//     Clk    rising-edge clock for all state
//     Reset  synchronous, active-high; aborts any multiply in progress
//     bus    mult_sequencer_if.slave (Run, ClearA_LoadB, Sw in;
//            Aval, Bval, Xval, Done, Busy out)
//
//   Also contains add_sub, the 9-bit-result adder/subtractor used for the
//   accumulate step.
// ----------------------------------------------------------------------------

// add_sub: sign-extends both operands by one bit so that the X:A
// accumulation cannot overflow; o_x is the extra (ninth) result bit.
module add_sub #(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    input  logic                    i_fn,   // 0: a + b, 1: a - b
    output logic        [WIDTH-1:0] o_s,
    output logic                    o_x
);
    logic signed [WIDTH:0] w_a_ext;
    logic signed [WIDTH:0] w_b_ext;
    logic signed [WIDTH:0] w_sum;

    assign w_a_ext = {i_a[WIDTH-1], i_a};
    assign w_b_ext = {i_b[WIDTH-1], i_b};
    assign w_sum   = i_fn ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);
    assign o_s     = w_sum[WIDTH-1:0];
    assign o_x     = w_sum[WIDTH];
endmodule

module mult_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    mult_sequencer_if.slave bus
);
    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic signed [WIDTH-1:0] r_a;
    logic signed [WIDTH-1:0] r_b;
    logic signed [WIDTH-1:0] r_m;
    logic                    r_x;
    logic        [CNT_W-1:0] r_cnt;
    logic                    r_run_q;

    logic                    w_start;
    logic                    w_fn;
    logic        [WIDTH-1:0] w_s;
    logic                    w_x;
    logic                    w_last_step;

    // Run is a level; only a low-to-high transition requests a multiply.
    // r_run_q resets high so a Run held through reset is not seen as an edge.
    assign w_start     = bus.Run & ~r_run_q;
    assign w_last_step = (r_cnt == CNT_LAST);
    assign w_fn        = (r_state == S_ADD) && w_last_step;

    add_sub #(.WIDTH(WIDTH)) u_add_sub (
        .i_a  (r_a),
        .i_b  (r_m),
        .i_fn (w_fn),
        .o_s  (w_s),
        .o_x  (w_x)
    );

    // ---- state register ----
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                // A load in the same cycle as a Run edge wins; the edge is lost.
                if (!bus.ClearA_LoadB && w_start) begin
                    w_next_state = S_ADD;
                end
            end
            S_ADD: begin
                w_next_state = S_SHIFT;
            end
            S_SHIFT: begin
                w_next_state = w_last_step ? S_HOLD : S_ADD;
            end
            S_HOLD: begin
                if (!bus.Run) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ---- output decode (registered state only, no input paths) ----
    always_comb begin
        bus.Busy = 1'b0;
        bus.Done = 1'b0;
        unique case (r_state)
            S_ADD, S_SHIFT: bus.Busy = 1'b1;
            S_HOLD:         bus.Done = 1'b1;
            default:        ;
        endcase
    end

    // ---- operand registers and step counter ----
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_m     <= '0;
            r_x     <= 1'b0;
            r_cnt   <= '0;
            r_run_q <= 1'b1;
        end else begin
            r_run_q <= bus.Run;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.ClearA_LoadB) begin
                        r_a <= '0;
                        r_x <= 1'b0;
                        r_b <= bus.Sw;
                    end else if (w_start) begin
                        // B is left alone so a previous low byte can chain in
                        // as the next multiplier.
                        r_a   <= '0;
                        r_x   <= 1'b0;
                        r_m   <= bus.Sw;
                        r_cnt <= '0;
                    end
                end
                S_ADD: begin
                    if (r_b[0]) begin
                        r_a <= w_s;
                        r_x <= w_x;
                    end
                end
                S_SHIFT: begin
                    // Arithmetic right shift of {X,A,B}; X replicates itself.
                    r_a <= {r_x, r_a[WIDTH-1:1]};
                    r_b <= {r_a[0], r_b[WIDTH-1:1]};
                    if (!w_last_step) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (bus.ClearA_LoadB) begin
                        r_a <= '0;
                        r_x <= 1'b0;
                        r_b <= bus.Sw;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Aval = r_a;
    assign bus.Bval = r_b;
    assign bus.Xval = r_x;
endmodule

// File: tb/tb_mult_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mult_sequencer
//   Directed bench for mult_sequencer. Expected products come from a simple
//   behavioural model (signed multiply of the modelled B register by the
//   multiplicand) pushed to a scoreboard queue at each start and popped when
//   the sequencer reports Done.
// ----------------------------------------------------------------------------
module tb_mult_sequencer;
    logic Clk;
    logic Reset;

    int checks = 0;
    int errors = 0;

    logic [16:0] sb_q[$];     // {X, A, B} expected per multiply
    logic [7:0]  mdl_b;       // bench model of the B register

    mult_sequencer_if #(.WIDTH(8)) bus ();

    mult_sequencer #(.WIDTH(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_b(input logic [7:0] v);
        bus.ClearA_LoadB = 1'b1;
        bus.Sw           = v;
        tick();
        bus.ClearA_LoadB = 1'b0;
        mdl_b            = v;
        check("load_B", bus.Bval, v);
        check("load_A", bus.Aval, 0);
        check("load_X", bus.Xval, 0);
    endtask

    // Caller guarantees Run has been low for at least one edge.
    task automatic run_mult(input logic [7:0] m, input bit noisy);
        logic signed [15:0] prod;
        logic [16:0]        exp;
        prod = $signed(mdl_b) * $signed(m);
        sb_q.push_back({prod[15], prod});
        mdl_b = prod[7:0];

        bus.Sw  = m;
        bus.Run = 1'b1;
        tick();                                  // start edge k
        check("busy_after_start", bus.Busy, 1);
        check("done_after_start", bus.Done, 0);

        for (int i = 1; i < 16; i++) begin
            if (noisy) begin
                bus.Sw           = 8'($urandom);
                bus.ClearA_LoadB = (i < 14) ? i[0] : 1'b0;
                bus.Run          = (i < 10) ? i[1] : 1'b1;
            end
            tick();
        end
        bus.ClearA_LoadB = 1'b0;
        bus.Run          = 1'b1;
        check("done_at_k15", bus.Done, 0);
        check("busy_at_k15", bus.Busy, 1);

        tick();                                  // edge k+16
        check("done_at_k16", bus.Done, 1);
        check("busy_at_k16", bus.Busy, 0);
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check("prod_A", bus.Aval, exp[15:8]);
            check("prod_B", bus.Bval, exp[7:0]);
            check("prod_X", bus.Xval, exp[16]);
        end else begin
            check("scoreboard_empty", 1, 0);
        end
    endtask

    task automatic drop_run();
        bus.Run = 1'b0;
        tick();
        check("idle_done", bus.Done, 0);
        check("idle_busy", bus.Busy, 0);
    endtask

    initial begin
        Reset            = 1'b1;
        bus.Run          = 1'b1;
        bus.ClearA_LoadB = 1'b0;
        bus.Sw           = 8'h00;
        mdl_b            = 8'h00;

        // Reset with Run held high
        repeat (3) tick();
        check("rst_A", bus.Aval, 0);
        check("rst_B", bus.Bval, 0);
        check("rst_X", bus.Xval, 0);
        check("rst_done", bus.Done, 0);
        check("rst_busy", bus.Busy, 0);
        Reset = 1'b0;
        repeat (3) tick();
        check("run_through_reset_busy", bus.Busy, 0);
        check("run_through_reset_done", bus.Done, 0);
        drop_run();

        // -7 * 3, then chain *2
        load_b(8'h03);
        run_mult(8'hF9, 1'b0);
        drop_run();
        run_mult(8'h02, 1'b0);
        check("chain_B", bus.Bval, 8'hD6);
        drop_run();

        // 7 * -3: final step subtracts
        load_b(8'hFD);
        run_mult(8'h07, 1'b0);
        drop_run();

        // -128 * -128
        load_b(8'h80);
        run_mult(8'h80, 1'b0);
        check("neg128sq_A", bus.Aval, 8'h40);

        // Run held high after completion: stays in HOLD
        repeat (20) tick();
        check("hold_done", bus.Done, 1);
        check("hold_busy", bus.Busy, 0);
        check("hold_B", bus.Bval, 8'h00);
        drop_run();
        load_b(8'h7F);
        run_mult(8'h81, 1'b0);
        repeat (5) tick();
        check("one_multiply_done", bus.Done, 1);
        drop_run();

        // Inputs toggling while busy
        load_b(8'hB5);
        run_mult(8'h6C, 1'b1);
        drop_run();

        // Load and Run edge in the same IDLE cycle: load wins, no start
        bus.ClearA_LoadB = 1'b1;
        bus.Sw           = 8'h05;
        bus.Run          = 1'b1;
        tick();
        bus.ClearA_LoadB = 1'b0;
        mdl_b            = 8'h05;
        check("simul_B", bus.Bval, 8'h05);
        check("simul_busy", bus.Busy, 0);
        repeat (3) tick();
        check("simul_no_start", bus.Busy, 0);
        drop_run();
        run_mult(8'h03, 1'b0);
        drop_run();

        // Reset mid-multiply (step 4)
        load_b(8'h55);
        bus.Sw  = 8'h09;
        bus.Run = 1'b1;
        tick();
        repeat (8) tick();
        check("midrun_busy", bus.Busy, 1);
        Reset = 1'b1;
        tick();
        mdl_b = 8'h00;
        check("abort_A", bus.Aval, 0);
        check("abort_B", bus.Bval, 0);
        check("abort_X", bus.Xval, 0);
        check("abort_busy", bus.Busy, 0);
        check("abort_done", bus.Done, 0);
        Reset = 1'b0;
        repeat (2) tick();
        check("abort_no_restart", bus.Busy, 0);
        drop_run();

        // 0x80 * 0x7F after reset recovery
        load_b(8'h80);
        run_mult(8'h7F, 1'b0);
        drop_run();

        check("scoreboard_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
